// File: rtl/tank_level_ctrl.sv
// Pump controller for a tank with NSENS stacked level sensors: synchronise, debounce, count, run a Moore FSM.
// Optional fill-timeout protection is compiled in with `define TANK_LEVEL_CTRL_TIMEOUT_EN.
module tank_level_ctrl #(
  parameter int NSENS        = 4,
  parameter int DEBOUNCE     = 2000,
  parameter int FILL_TIMEOUT = 30000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NSENS-1:0]             lvl,
  input  logic                         clr,
  output logic                         motor,
  output logic                         s_empty,
  output logic                         s_full,
  output logic                         fault,
  output logic [$clog2(NSENS+1)-1:0]   level
);

  localparam int LW = $clog2(NSENS+1);
  localparam int CW = $clog2(DEBOUNCE+1);
  localparam int IW = $clog2(DEBOUNCE+4);

  typedef enum logic [1:0] {INIT, HOLD, FILL, FAULT} state_t;

  function automatic logic [LW-1:0] popcnt(input logic [NSENS-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < NSENS; i++) n = n + LW'(v[i]);
    return n;
  endfunction

  function automatic logic is_thermo(input logic [NSENS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 1; k < NSENS; k++)
      if (v[k] && !v[k-1]) ok = 1'b0;
    return ok;
  endfunction

  function automatic state_t decide(input logic cons, input logic [LW-1:0] l);
    if (!cons)         return FAULT;
    else if (l == '0)  return FILL;
    else               return HOLD;
  endfunction

  logic [NSENS-1:0] sync1_q, sync2_q;
  logic [NSENS-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q [NSENS];
  logic [CW-1:0]    cnt_d [NSENS];
  logic [LW-1:0]    level_q, level_d;
  logic             cons_q;
  logic [IW-1:0]    init_q, init_d;
  state_t           state_q, state_d;
  logic             tmo_exp;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NSENS; i++) begin
      cnt_d[i] = '0;
      // The counter only runs while the synchronised input disagrees with the debounced bit.
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE-1)) deb_d[i] = sync2_q[i];
        else                             cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign level_d = popcnt(deb_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < NSENS; i++) cnt_q[i] <= '0;
      level_q <= '0;
      cons_q  <= 1'b1;
    end else begin
      sync1_q <= lvl;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < NSENS; i++) cnt_q[i] <= cnt_d[i];
      level_q <= level_d;
      cons_q  <= is_thermo(deb_q);
    end
  end

`ifdef TANK_LEVEL_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(FILL_TIMEOUT+1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          level_rise;

  // level_d is the popcount about to be registered, so a rise is seen the cycle it lands.
  assign level_rise = (level_d > level_q);
  assign tmo_exp    = (state_q == FILL) && !level_rise && (tmo_q == TW'(FILL_TIMEOUT-1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q != FILL || level_rise) tmo_d = '0;
    else                               tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    case (state_q)
      INIT: begin
        if (init_q == IW'(DEBOUNCE+2)) state_d = decide(cons_q, level_q);
        else                           init_d  = init_q + 1'b1;
      end
      HOLD: begin
        if (!cons_q)              state_d = FAULT;
        else if (level_q == '0)   state_d = FILL;
      end
      FILL: begin
        // Reaching the top wins over a simultaneous timeout expiry.
        if (!cons_q)                       state_d = FAULT;
        else if (level_q == LW'(NSENS))    state_d = HOLD;
        else if (tmo_exp)                  state_d = FAULT;
      end
      FAULT: begin
        if (clr && cons_q) state_d = decide(cons_q, level_q);
      end
      default: state_d = INIT;
    endcase
  end

  // Outputs decode the next state and level so they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= INIT;
      init_q  <= '0;
      motor   <= 1'b0;
      fault   <= 1'b0;
      s_empty <= 1'b0;
      s_full  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      motor   <= (state_d == FILL);
      fault   <= (state_d == FAULT);
      s_empty <= (state_d == HOLD || state_d == FILL) && (level_d == '0);
      s_full  <= (state_d == HOLD || state_d == FILL) && (level_d == LW'(NSENS));
    end
  end

  assign level = level_q;

endmodule
